// File: rtl/demux4_queued_if.sv
// demux4_queued_if
//  Bundles the producer-side val/rdy stream and the four consumer-side
//  channels of demux4_queued.
//  Producer side : in_val, in_rdy, in_sel, in_data
//  Consumer side : outN_val, outN_rdy, outN_data, outN_cnt   (N = 0..3)
//  modport slave  - the demux itself (accepts in_*, drives outN_*)
//  modport master - the surrounding producer/consumers
interface demux4_queued_if #(
    parameter int p_nbits = 4,
    parameter int p_depth = 2
);
    localparam int c_cw = $clog2(p_depth) + 1;

    logic               in_val;
    logic               in_rdy;
    logic [1:0]         in_sel;
    logic [p_nbits-1:0] in_data;

    logic               out0_val;
    logic               out0_rdy;
    logic [p_nbits-1:0] out0_data;
    logic [c_cw-1:0]    out0_cnt;

    logic               out1_val;
    logic               out1_rdy;
    logic [p_nbits-1:0] out1_data;
    logic [c_cw-1:0]    out1_cnt;

    logic               out2_val;
    logic               out2_rdy;
    logic [p_nbits-1:0] out2_data;
    logic [c_cw-1:0]    out2_cnt;

    logic               out3_val;
    logic               out3_rdy;
    logic [p_nbits-1:0] out3_data;
    logic [c_cw-1:0]    out3_cnt;

    modport slave (
        input  in_val, in_sel, in_data,
        output in_rdy,
        input  out0_rdy, out1_rdy, out2_rdy, out3_rdy,
        output out0_val, out0_data, out0_cnt,
        output out1_val, out1_data, out1_cnt,
        output out2_val, out2_data, out2_cnt,
        output out3_val, out3_data, out3_cnt
    );

    modport master (
        output in_val, in_sel, in_data,
        input  in_rdy,
        output out0_rdy, out1_rdy, out2_rdy, out3_rdy,
        input  out0_val, out0_data, out0_cnt,
        input  out1_val, out1_data, out1_cnt,
        input  out2_val, out2_data, out2_cnt,
        input  out3_val, out3_data, out3_cnt
    );
endinterface

// File: rtl/demux4_queued.sv
// demux4_queued
//  Routes one val/rdy input stream to one of four output channels selected
//  per transaction by in_sel. Every channel owns a p_depth-entry FIFO so a
//  stalled consumer only blocks its own channel; order is kept per channel.
//  Ports:
//   clk  - clock, all state changes on posedge
//   rst  - synchronous active-high reset (drops every queued entry)
//   bus  - demux4_queued_if.slave: in_val/in_rdy/in_sel/in_data and
//          outN_val/outN_rdy/outN_data/outN_cnt for N = 0..3
//  in_rdy is the only combinational output (full flag of the selected
//  channel); all outN_* come straight from registers.
module demux4_queued #(
    parameter int p_nbits = 4,
    parameter int p_depth = 2
) (
    input  logic            clk,
    input  logic            rst,
    demux4_queued_if.slave  bus
);
    localparam int c_pw = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int c_cw = $clog2(p_depth) + 1;

    localparam logic [c_cw-1:0]    c_cnt_zero  = {c_cw{1'b0}};
    localparam logic [c_cw-1:0]    c_cnt_full  = c_cw'(p_depth);
    localparam logic [c_pw-1:0]    c_ptr_zero  = {c_pw{1'b0}};
    localparam logic [c_pw-1:0]    c_ptr_one   = c_pw'(1'b1);
    localparam logic [p_nbits-1:0] c_data_zero = {p_nbits{1'b0}};

    // Per-channel state
    logic [p_nbits-1:0] mem_r      [4][p_depth];
    logic [c_cw-1:0]    cnt_r      [4];
    logic [c_pw-1:0]    wr_ptr_r   [4];
    logic [c_pw-1:0]    rd_ptr_r   [4];
    logic [p_nbits-1:0] head_r     [4];
    logic [3:0]         val_r;

    // Per-channel next-state terms
    logic [3:0]         ordy_s;
    logic [3:0]         full_s;
    logic [3:0]         enq_s;
    logic [3:0]         deq_s;
    logic [c_cw-1:0]    cnt_nxt_s  [4];
    logic [c_pw-1:0]    wr_nxt_s   [4];
    logic [c_pw-1:0]    rd_nxt_s   [4];
    logic [p_nbits-1:0] head_nxt_s [4];

    assign ordy_s = {bus.out3_rdy, bus.out2_rdy, bus.out1_rdy, bus.out0_rdy};

    // Handshake decode and next FIFO state for every channel
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full_s[i]    = (cnt_r[i] == c_cnt_full);
            enq_s[i]     = bus.in_val && !full_s[i] && (bus.in_sel == 2'(i));
            // val_r mirrors cnt_r != 0, so the pop gate uses the registered flag
            deq_s[i]     = val_r[i] && ordy_s[i];
            cnt_nxt_s[i] = cnt_r[i] + c_cw'(enq_s[i]) - c_cw'(deq_s[i]);
            wr_nxt_s[i]  = enq_s[i] ? (wr_ptr_r[i] + c_ptr_one) : wr_ptr_r[i];
            rd_nxt_s[i]  = deq_s[i] ? (rd_ptr_r[i] + c_ptr_one) : rd_ptr_r[i];
            // Head for next cycle: the entry being written this edge lands at
            // rd_nxt when the FIFO was empty (or is being emptied to it), so
            // take it from in_data instead of the not-yet-updated array.
            if (cnt_nxt_s[i] == c_cnt_zero) begin
                head_nxt_s[i] = c_data_zero;
            end else if (enq_s[i] && (wr_ptr_r[i] == rd_nxt_s[i])) begin
                head_nxt_s[i] = bus.in_data;
            end else begin
                head_nxt_s[i] = mem_r[i][rd_nxt_s[i]];
            end
        end
    end

    // Ready depends only on the selected channel's occupancy (no bypass)
    assign bus.in_rdy = !full_s[bus.in_sel];

    // Pointers, occupancy and registered head/valid per channel
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i]    <= c_cnt_zero;
                wr_ptr_r[i] <= c_ptr_zero;
                rd_ptr_r[i] <= c_ptr_zero;
                head_r[i]   <= c_data_zero;
                val_r[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i]    <= cnt_nxt_s[i];
                wr_ptr_r[i] <= wr_nxt_s[i];
                rd_ptr_r[i] <= rd_nxt_s[i];
                head_r[i]   <= head_nxt_s[i];
                val_r[i]    <= (cnt_nxt_s[i] != c_cnt_zero);
            end
        end
    end

    // Storage write; array contents are intentionally left uncleared by reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst && enq_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= bus.in_data;
            end
        end
    end

    assign bus.out0_val  = val_r[0];
    assign bus.out1_val  = val_r[1];
    assign bus.out2_val  = val_r[2];
    assign bus.out3_val  = val_r[3];
    assign bus.out0_data = head_r[0];
    assign bus.out1_data = head_r[1];
    assign bus.out2_data = head_r[2];
    assign bus.out3_data = head_r[3];
    assign bus.out0_cnt  = cnt_r[0];
    assign bus.out1_cnt  = cnt_r[1];
    assign bus.out2_cnt  = cnt_r[2];
    assign bus.out3_cnt  = cnt_r[3];

endmodule

// File: tb/tb_demux4_queued.sv
// tb_demux4_queued
//  Directed bench for demux4_queued (p_nbits=4, p_depth=2). Inputs change
//  1 time unit after each rising edge; outputs are checked there as well.
module tb_demux4_queued;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    demux4_queued_if #(.p_nbits(4), .p_depth(2)) bus ();

    demux4_queued #(.p_nbits(4), .p_depth(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] val_w;
    logic [3:0] data_w [4];
    logic [1:0] cnt_w  [4];
    assign val_w     = {bus.out3_val, bus.out2_val, bus.out1_val, bus.out0_val};
    assign data_w[0] = bus.out0_data;
    assign data_w[1] = bus.out1_data;
    assign data_w[2] = bus.out2_data;
    assign data_w[3] = bus.out3_data;
    assign cnt_w[0]  = bus.out0_cnt;
    assign cnt_w[1]  = bus.out1_cnt;
    assign cnt_w[2]  = bus.out2_cnt;
    assign cnt_w[3]  = bus.out3_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdy(input logic [3:0] r);
        bus.out0_rdy = r[0];
        bus.out1_rdy = r[1];
        bus.out2_rdy = r[2];
        bus.out3_rdy = r[3];
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d);
        bus.in_val  = v;
        bus.in_sel  = s;
        bus.in_data = d;
    endtask

    task automatic chk_all_empty(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s val%0d", tag, i), 32'(val_w[i]), 32'd0);
            chk($sformatf("%s cnt%0d", tag, i), 32'(cnt_w[i]), 32'd0);
            chk($sformatf("%s data%0d", tag, i), 32'(data_w[i]), 32'd0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive(1'b0, 2'd0, 4'h0);
        set_rdy(4'b0000);

        // 1 Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_all_empty("reset");
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            chk($sformatf("reset in_rdy sel%0d", s), 32'(bus.in_rdy), 32'd1);
        end

        // 2 Route to channel 2
        drive(1'b1, 2'd2, 4'hA);
        #1;
        chk("route in_rdy", 32'(bus.in_rdy), 32'd1);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        chk("route val", 32'(val_w), 32'b0100);
        chk("route data2", 32'(bus.out2_data), 32'hA);
        chk("route cnt2", 32'(bus.out2_cnt), 32'd1);
        set_rdy(4'b0100);
        tick();
        set_rdy(4'b0000);
        chk("route pop val2", 32'(bus.out2_val), 32'd0);
        chk("route pop cnt2", 32'(bus.out2_cnt), 32'd0);
        chk("route pop data2", 32'(bus.out2_data), 32'h0);

        // 3 Backpressure on channel 1, channel 0 unaffected
        drive(1'b1, 2'd1, 4'h1);
        tick();
        drive(1'b1, 2'd1, 4'h2);
        tick();
        drive(1'b0, 2'd1, 4'h0);
        #1;
        chk("bp in_rdy sel1", 32'(bus.in_rdy), 32'd0);
        chk("bp cnt1", 32'(bus.out1_cnt), 32'd2);
        chk("bp head1", 32'(bus.out1_data), 32'h1);
        bus.in_sel = 2'd0;
        #1;
        chk("bp in_rdy sel0", 32'(bus.in_rdy), 32'd1);
        drive(1'b1, 2'd0, 4'h3);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        chk("bp ch0 val", 32'(bus.out0_val), 32'd1);
        chk("bp ch0 data", 32'(bus.out0_data), 32'h3);
        chk("bp cnt1 held", 32'(bus.out1_cnt), 32'd2);
        set_rdy(4'b0011);
        tick();
        chk("bp drain1 first", 32'(bus.out1_data), 32'h2);
        chk("bp drain1 cnt", 32'(bus.out1_cnt), 32'd1);
        chk("bp drain0 cnt", 32'(bus.out0_cnt), 32'd0);
        tick();
        set_rdy(4'b0000);
        chk("bp drain1 val", 32'(bus.out1_val), 32'd0);
        chk("bp drain1 cnt0", 32'(bus.out1_cnt), 32'd0);

        // 4 Simultaneous enqueue and dequeue on channel 3
        drive(1'b1, 2'd3, 4'h5);
        tick();
        chk("sim cnt3 pre", 32'(bus.out3_cnt), 32'd1);
        chk("sim data3 pre", 32'(bus.out3_data), 32'h5);
        drive(1'b1, 2'd3, 4'h6);
        set_rdy(4'b1000);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        set_rdy(4'b0000);
        chk("sim cnt3", 32'(bus.out3_cnt), 32'd1);
        chk("sim data3", 32'(bus.out3_data), 32'h6);
        set_rdy(4'b1000);
        tick();
        set_rdy(4'b0000);
        chk("sim drain cnt3", 32'(bus.out3_cnt), 32'd0);

        // 5 Full channel 0 with pop: no bypass into the freed slot
        drive(1'b1, 2'd0, 4'h7);
        tick();
        drive(1'b1, 2'd0, 4'h8);
        tick();
        drive(1'b1, 2'd0, 4'h9);
        set_rdy(4'b0001);
        #1;
        chk("full in_rdy", 32'(bus.in_rdy), 32'd0);
        tick();
        set_rdy(4'b0000);
        chk("full after pop cnt", 32'(bus.out0_cnt), 32'd1);
        chk("full after pop data", 32'(bus.out0_data), 32'h8);
        chk("full after pop in_rdy", 32'(bus.in_rdy), 32'd1);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        chk("full accept cnt", 32'(bus.out0_cnt), 32'd2);
        chk("full accept head", 32'(bus.out0_data), 32'h8);
        set_rdy(4'b0001);
        tick();
        chk("full drain second", 32'(bus.out0_data), 32'h9);
        chk("full drain cnt", 32'(bus.out0_cnt), 32'd1);
        tick();
        set_rdy(4'b0000);
        chk("full drain val", 32'(bus.out0_val), 32'd0);

        // 6 Reset mid-operation with a pending input
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), 4'(4'hB + s));
            tick();
        end
        drive(1'b0, 2'd0, 4'h0);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("midop pre cnt%0d", s), 32'(cnt_w[s]), 32'd1);
        end
        chk("midop pre data2", 32'(data_w[2]), 32'hD);
        rst = 1'b1;
        drive(1'b1, 2'd0, 4'hF);
        set_rdy(4'b1111);
        tick();
        rst = 1'b0;
        drive(1'b0, 2'd0, 4'h0);
        set_rdy(4'b0000);
        #1;
        chk_all_empty("midop");
        chk("midop in_rdy", 32'(bus.in_rdy), 32'd1);
        tick();
        chk("midop no enq cnt0", 32'(bus.out0_cnt), 32'd0);
        chk("midop no enq val0", 32'(bus.out0_val), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
